// File: rtl/cl_pkg.sv
// Shared definitions for the CameraLink-to-AXI4-Stream packer.
//   state_t : packer frame FSM states
//   beat_t  : one buffered output beat {tuser, tlast, tdata}
package cl_pkg;

  localparam int PIX_W  = 12;
  localparam int AXIS_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [AXIS_W-1:0] tdata;
  } beat_t;

endpackage

// File: rtl/cl_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : synchronous empty, dominates any write in the same cycle
//   wr_en/din     : push; accepted when not full, or when full with a pop this cycle
//   full          : no free entry
//   rd_en         : pop head (ignored while empty)
//   dout          : head entry, valid while ~empty
//   empty         : no entry
module cl_sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cameralink_axis_packer.sv
// Packs the CameraLink PHY pixel stream into 64-bit AXI4-Stream beats.
//   sys_clk, sys_rst         : clock, synchronous active-high reset
//   pixel_data_i/pixel_vld_i : {px3,px2,px1,px0} words (px1,px0 only when cameraSel=0)
//   new_frame_i/frame_valid_i: frame start pulse, frame active level
//   cameraSel/lineWidth/frameHeight : format, latched on new_frame_i
//   m_axis_*                 : beat stream, 4 zero-extended pixels per beat,
//                              tlast = line end, tuser = frame start
//   camera_in_progress       : high while a frame is being transferred
//   frame_done               : pulse once the last beat of a frame has left
//   overflow/frame_abort     : sticky error flags
module cameralink_axis_packer
  import cl_pkg::*;
#(
  parameter int PIX_W      = 12,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [4*PIX_W-1:0]   pixel_data_i,
  input  logic                 pixel_vld_i,
  input  logic                 new_frame_i,
  input  logic                 frame_valid_i,
  input  logic                 cameraSel,
  input  logic [CNT_W-1:0]     lineWidth,
  input  logic [CNT_W-1:0]     frameHeight,
  output logic [AXIS_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 camera_in_progress,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 frame_abort
);

  state_t           state;
  logic [CNT_W-1:0] lw_r, fh_r, pix_cnt, line_cnt;
  logic             sel_r, half, first, fv_d;
  logic [31:0]      pack_lo;
  logic             wr_en_r;
  beat_t            wr_beat;

  logic [CNT_W:0]   pix_next;
  logic             line_end, frame_end, fv_fall, flush, arm;
  logic [31:0]      px_lo, px_hi;
  logic             beat_we, beat_last;
  logic [63:0]      beat_data;
  logic             fifo_full, fifo_empty, fifo_pop;
  beat_t            fifo_dout;

  function automatic logic [31:0] ext2(input logic [2*PIX_W-1:0] px);
    logic [31:0] r;
    r = '0;
    r[PIX_W-1:0]   = px[PIX_W-1:0];
    r[16 +: PIX_W] = px[PIX_W +: PIX_W];
    return r;
  endfunction

  assign px_lo     = ext2(pixel_data_i[2*PIX_W-1:0]);
  assign px_hi     = ext2(pixel_data_i[4*PIX_W-1:2*PIX_W]);
  assign pix_next  = {1'b0, pix_cnt} + (sel_r ? (CNT_W+1)'(4) : (CNT_W+1)'(2));
  assign line_end  = pix_next >= {1'b0, lw_r};
  assign frame_end = line_end && (({1'b0, line_cnt} + (CNT_W+1)'(1)) >= {1'b0, fh_r});
  assign fv_fall   = fv_d && !frame_valid_i;
  assign flush     = new_frame_i && (state != IDLE);
  assign arm       = (lineWidth != '0) && (frameHeight != '0);
  assign fifo_pop  = m_axis_tready && !fifo_empty;

  // Beat assembly; a frame_valid drop takes priority over a same-cycle word.
  always_comb begin
    beat_we   = 1'b0;
    beat_last = 1'b0;
    beat_data = '0;
    if (state == ACTIVE && !new_frame_i) begin
      if (fv_fall) begin
        beat_we   = half;
        beat_last = 1'b1;
        beat_data = {32'h0, pack_lo};
      end else if (pixel_vld_i) begin
        if (sel_r) begin
          beat_we   = 1'b1;
          beat_last = line_end;
          beat_data = {px_hi, px_lo};
        end else if (half) begin
          beat_we   = 1'b1;
          beat_last = line_end;
          beat_data = {px_lo, pack_lo};
        end else if (line_end) begin
          beat_we   = 1'b1;
          beat_last = 1'b1;
          beat_data = {32'h0, px_lo};
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      lw_r        <= '0;
      fh_r        <= '0;
      sel_r       <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      half        <= 1'b0;
      first       <= 1'b0;
      pack_lo     <= '0;
      fv_d        <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_beat     <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      fv_d       <= frame_valid_i;
      wr_en_r    <= 1'b0;
      frame_done <= 1'b0;
      if (wr_en_r && fifo_full && !fifo_pop && !flush) overflow <= 1'b1;

      if (beat_we) begin
        wr_en_r <= 1'b1;
        wr_beat <= '{tuser: first, tlast: beat_last, tdata: beat_data};
        first   <= 1'b0;
      end

      if (new_frame_i) begin
        // Restart from any state: re-latch format and clear pack/count state.
        if (state != IDLE) frame_abort <= 1'b1;
        lw_r     <= lineWidth;
        fh_r     <= frameHeight;
        sel_r    <= cameraSel;
        pix_cnt  <= '0;
        line_cnt <= '0;
        half     <= 1'b0;
        first    <= 1'b1;
        state    <= arm ? ACTIVE : IDLE;
      end else begin
        case (state)
          ACTIVE: begin
            if (fv_fall) begin
              half  <= 1'b0;
              state <= DRAIN;
            end else if (pixel_vld_i) begin
              pix_cnt <= line_end ? '0 : pix_next[CNT_W-1:0];
              if (line_end)  line_cnt <= line_cnt + 1'b1;
              if (frame_end) state <= DRAIN;
              if (!sel_r) begin
                if (half) begin
                  half <= 1'b0;
                end else if (!line_end) begin
                  pack_lo <= px_lo;
                  half    <= 1'b1;
                end
              end
            end
          end
          DRAIN: begin
            if (!wr_en_r && fifo_empty) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  cl_sync_fifo #(
    .WIDTH($bits(beat_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .flush(flush),
    .wr_en(wr_en_r),
    .din  (wr_beat),
    .full (fifo_full),
    .rd_en(m_axis_tready),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  assign m_axis_tvalid      = !fifo_empty;
  assign m_axis_tdata       = fifo_empty ? '0 : fifo_dout.tdata;
  assign m_axis_tlast       = !fifo_empty && fifo_dout.tlast;
  assign m_axis_tuser       = !fifo_empty && fifo_dout.tuser;
  assign camera_in_progress = (state != IDLE);

endmodule

// File: tb/tb_cameralink_axis_packer.sv
module tb_cameralink_axis_packer;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [47:0] pixel_data;
  logic        pixel_vld, new_frame, frame_valid, sel;
  logic [15:0] line_width, frame_height;
  logic [63:0] tdata;
  logic        tvalid, tready, tlast, tuser;
  logic        in_prog, frame_done, overflow, frame_abort;

  always #5 clk = ~clk;

  cameralink_axis_packer #(
    .PIX_W(12),
    .FIFO_DEPTH(16),
    .CNT_W(16)
  ) dut (
    .sys_clk(clk),
    .sys_rst(sys_rst),
    .pixel_data_i(pixel_data),
    .pixel_vld_i(pixel_vld),
    .new_frame_i(new_frame),
    .frame_valid_i(frame_valid),
    .cameraSel(sel),
    .lineWidth(line_width),
    .frameHeight(frame_height),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast(tlast),
    .m_axis_tuser(tuser),
    .camera_in_progress(in_prog),
    .frame_done(frame_done),
    .overflow(overflow),
    .frame_abort(frame_abort)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int got_cnt = 0;

  logic [65:0] exp_q[$];   // {tuser, tlast, tdata}
  logic [47:0] sent[$];

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 12-bit pixels zero-extended into 16-bit lanes.
  function automatic logic [31:0] lanes2(input logic [23:0] w);
    logic [31:0] r;
    for (int p = 0; p < 2; p++) r[16*p +: 16] = {4'h0, w[12*p +: 12]};
    return r;
  endfunction

  // Reference model: split the word list into lines, then lines into beats.
  // A trailing partial group means the frame was cut short by frame_valid.
  task automatic model_frame(input bit s, input int lw, input int max_beats);
    int  wpl, idx, n, nb;
    bit  full_line;
    logic [65:0] b;
    wpl = s ? (lw + 3) / 4 : lw / 2;
    idx = 0;
    nb  = 0;
    while (idx < sent.size()) begin
      n = sent.size() - idx;
      full_line = (n >= wpl);
      if (full_line) n = wpl;
      if (s) begin
        for (int i = 0; i < n; i++) begin
          b = {(nb == 0), (full_line && i == n - 1),
               lanes2(sent[idx+i][47:24]), lanes2(sent[idx+i][23:0])};
          if (nb < max_beats) exp_q.push_back(b);
          nb++;
        end
      end else begin
        for (int i = 0; i < n; i += 2) begin
          if (i + 1 < n)
            b = {(nb == 0), (full_line && i + 2 >= n),
                 lanes2(sent[idx+i+1][23:0]), lanes2(sent[idx+i][23:0])};
          else
            b = {(nb == 0), 1'b1, 32'h0, lanes2(sent[idx+i][23:0])};
          if (nb < max_beats) exp_q.push_back(b);
          nb++;
        end
      end
      idx += n;
    end
  endtask

  // Output monitor: scoreboard compare and hold-stability while stalled.
  logic        hold_v = 1'b0;
  logic [65:0] hold_b;
  always @(negedge clk) begin
    if (!sys_rst) begin
      if (frame_done) done_cnt++;
      if (hold_v && tvalid) chk("hold_stable", {tuser, tlast, tdata}, hold_b);
      if (tvalid && tready) begin
        got_cnt++;
        if (exp_q.size() == 0) chk("unexpected_beat", 66'd1, 66'd0);
        else chk("beat", {tuser, tlast, tdata}, exp_q.pop_front());
      end
      hold_v = tvalid && !tready;
      hold_b = {tuser, tlast, tdata};
    end
  end

  task automatic start_frame(input bit s, input int lw, input int fh);
    sel = s;
    line_width = 16'(lw);
    frame_height = 16'(fh);
    new_frame = 1'b1;
    frame_valid = 1'b1;
    tick();
    new_frame = 1'b0;
    sent.delete();
  endtask

  task automatic gen_words(input int n);
    for (int i = 0; i < n; i++) sent.push_back({$urandom, $urandom});
  endtask

  // Feed words [from, from+n) of the prepared list.
  task automatic feed(input int from, input int n, input bit rnd);
    for (int i = from; i < from + n; i++) begin
      if (rnd) begin
        tready = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) tick();
      end
      pixel_data = sent[i];
      pixel_vld = 1'b1;
      tick();
      pixel_vld = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int start, k;
    start = done_cnt;
    k = 0;
    tready = 1'b1;
    while (done_cnt == start && k < 500) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, 66'(done_cnt != start), 66'd1);
    repeat (3) tick();
    frame_valid = 1'b0;
    chk({tag, "_done_single"}, 66'(done_cnt - start), 66'd1);
    chk({tag, "_idle"}, 66'(in_prog), 66'd0);
    chk({tag, "_all_beats"}, 66'(exp_q.size()), 66'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s, lw, fh, wpl;
    logic [47:0] w;

    sys_rst = 1'b1;
    pixel_data = '0; pixel_vld = 1'b0; new_frame = 1'b0; frame_valid = 1'b0;
    sel = 1'b0; line_width = '0; frame_height = '0; tready = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", {tvalid, tlast, tuser, in_prog, frame_done, overflow, frame_abort}, 66'd0);
    chk("rst_tdata", 66'(tdata), 66'd0);
    sys_rst = 1'b0;
    tick();

    // Four-pixel words, pixels 1..16, two lines of two beats.
    start_frame(1, 8, 2);
    chk("t1_in_progress", 66'(in_prog), 66'd1);
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) w[12*p +: 12] = 12'(4*k + p + 1);
      sent.push_back(w);
    end
    model_frame(1, 8, 1000);
    base = got_cnt;
    feed(0, 1, 0);
    chk("t1_latency_early", 66'(tvalid), 66'd0);
    tick();
    chk("t1_latency_valid", 66'(tvalid), 66'd1);
    feed(1, 3, 0);
    wait_done("t1");
    chk("t1_beat_count", 66'(got_cnt - base), 66'd4);

    // Two-pixel words, line of 6 pixels ends on a half beat.
    start_frame(0, 6, 1);
    gen_words(3);
    model_frame(0, 6, 1000);
    base = got_cnt;
    feed(0, 3, 0);
    wait_done("t2");
    chk("t2_beat_count", 66'(got_cnt - base), 66'd2);

    // 16-beat line under a 40-cycle stall: exactly fills the FIFO.
    start_frame(1, 64, 1);
    gen_words(16);
    model_frame(1, 64, 1000);
    tready = 1'b0;
    feed(0, 16, 0);
    repeat (24) tick();
    chk("t3_stalled_valid", 66'(tvalid), 66'd1);
    wait_done("t3");
    chk("t3_no_overflow", 66'(overflow), 66'd0);

    // Randomised frames with random backpressure and input gaps.
    for (int f = 0; f < 6; f++) begin
      s  = $urandom_range(0, 1);
      lw = 2 * $urandom_range(1, 10);
      fh = $urandom_range(1, 3);
      wpl = s ? (lw + 3) / 4 : lw / 2;
      start_frame(1'(s), lw, fh);
      gen_words(wpl * fh);
      model_frame(1'(s), lw, 1000);
      feed(0, wpl * fh, 1);
      wait_done("rand");
    end
    chk("rand_no_overflow", 66'(overflow), 66'd0);

    // frame_valid drops after 1.5 lines of two-pixel words.
    start_frame(0, 12, 4);
    gen_words(9);
    model_frame(0, 12, 1000);
    feed(0, 9, 0);
    frame_valid = 1'b0;
    tick();
    wait_done("t5");

    // Abort in line 3 of 10 with a beat still buffered.
    start_frame(1, 8, 10);
    gen_words(4);
    model_frame(1, 8, 1000);
    feed(0, 4, 0);
    repeat (4) tick();
    chk("t6_lines_delivered", 66'(exp_q.size()), 66'd0);
    tready = 1'b0;
    pixel_data = {$urandom, $urandom};
    pixel_vld = 1'b1;
    tick();
    pixel_vld = 1'b0;
    repeat (3) tick();
    chk("t6_buffered", 66'(tvalid), 66'd1);
    chk("t6_no_abort_yet", 66'(frame_abort), 66'd0);
    start_frame(1, 8, 2);
    chk("t6_flushed", 66'(tvalid), 66'd0);
    chk("t6_abort_flag", 66'(frame_abort), 66'd1);
    chk("t6_still_active", 66'(in_prog), 66'd1);
    gen_words(4);
    model_frame(1, 8, 1000);
    tready = 1'b1;
    feed(0, 4, 0);
    wait_done("t6");

    // 20 beats into a 16-deep FIFO with no ready: 4 beats dropped.
    start_frame(1, 40, 2);
    gen_words(20);
    model_frame(1, 40, 16);
    tready = 1'b0;
    base = got_cnt;
    feed(0, 20, 0);
    repeat (3) tick();
    chk("t7_overflow", 66'(overflow), 66'd1);
    wait_done("t7");
    chk("t7_delivered", 66'(got_cnt - base), 66'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
